// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port arbiter/sequencer in front of a single-port ram.
// Port 0 (instruction fetch) and port 1 (load/store) each run a req/ack
// handshake. One access is granted at a time. It gets a one-cycle
// read/write strobe to the ram, then waits for the matching ready (bounded by
// `timeout`) and completes with a one-cycle ack (with err if the ram stayed
// silent).
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mN_req/we/addr/wdata    port N request and operands (held until ack)
//   mN_rdata/ack/err        port N read data, completion pulse, timeout flag
//   ram_address/data_in     operands to the ram (held until the next grant)
//   ram_data_out            read data from the ram
//   ram_read/ram_write      one-cycle access strobes
//   ram_ready_r/ready_w     ram completion for read / write
module ram_arbiter #(
    parameter int size_addr = 8,
    parameter int timeout   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [size_addr-1:0] m0_addr,
    input  logic [7:0]           m0_wdata,
    output logic [7:0]           m0_rdata,
    output logic                 m0_ack,
    output logic                 m0_err,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [size_addr-1:0] m1_addr,
    input  logic [7:0]           m1_wdata,
    output logic [7:0]           m1_rdata,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic [size_addr-1:0] ram_address,
    output logic [7:0]           ram_data_in,
    input  logic [7:0]           ram_data_out,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic                 ram_ready_r,
    input  logic                 ram_ready_w
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TMO = 8'(timeout);

    state_t     state_q;
    logic       gnt_q;    // port owning the access in flight
    logic       last_q;   // port granted most recently
    logic       we_q;     // direction of the access in flight
    logic [7:0] cnt_q;    // cycles spent in WAIT

    logic pick;
    logic sel_we;
    logic tgt_rdy;

    // On a tie the port that did not go last wins.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) pick = ~last_q;
        else if (m1_req)      pick = 1'b1;
    end

    assign sel_we  = pick ? m1_we : m0_we;
    // Only the ready matching the direction of the access counts.
    assign tgt_rdy = we_q ? ram_ready_w : ram_ready_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            m0_rdata    <= '0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m1_rdata    <= '0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_q       <= pick;
                        last_q      <= pick;
                        we_q        <= sel_we;
                        ram_address <= pick ? m1_addr  : m0_addr;
                        ram_data_in <= pick ? m1_wdata : m0_wdata;
                        ram_read    <= ~sel_we;
                        ram_write   <= sel_we;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (tgt_rdy) begin
                        if (!we_q) begin
                            if (gnt_q) m1_rdata <= ram_data_out;
                            else       m0_rdata <= ram_data_out;
                        end
                        if (gnt_q) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        // cnt_q never exceeds timeout-1 here, so no wrap.
                        if (cnt_q + 8'd1 == TMO) begin
                            if (gnt_q) begin
                                m1_ack <= 1'b1;
                                m1_err <= 1'b1;
                            end else begin
                                m0_ack <= 1'b1;
                                m0_err <= 1'b1;
                            end
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Requests are not sampled here so a port dropping req on
                    // its ack edge is not granted a second time.
                    m0_ack  <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m1_err  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural ram with programmable
// latency, stub (never ready) and spurious opposite-ready noise, plus a
// transaction-level model (shadow memory, alternate-on-tie grant order).
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] ram_address, ram_data_in;
    logic [7:0] ram_data_out = 8'h00;
    logic       ram_read, ram_write;
    logic       ram_ready_r = 1'b0, ram_ready_w = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    int  lat   = 0;
    bit  stub  = 0;
    bit  noise = 0;
    bit  pend  = 0;
    int  dcnt  = 0;
    bit  op_w  = 0;

    ram_arbiter #(.size_addr(8), .timeout(5)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_ready_r(ram_ready_r), .ram_ready_w(ram_ready_w)
    );

    always #5 clk = ~clk;

    // Behavioural ram: strobe seen at an edge, ready pulse `lat` edges later.
    always @(posedge clk) begin
        bit done;
        done = 1'b0;
        if (reset) pend = 1'b0;
        else begin
            if (ram_read || ram_write) begin
                pend = 1'b1;
                dcnt = lat;
                op_w = ram_write;
                if (ram_write) mem[ram_address] = ram_data_in;
                else ram_data_out <= mem[ram_address];
            end
            if (pend) begin
                if (dcnt == 0) begin
                    done = 1'b1;
                    pend = 1'b0;
                end else dcnt--;
            end
        end
        ram_ready_r <= (done && !op_w && !stub) || (noise && op_w && ($urandom % 2 == 1));
        ram_ready_w <= (done &&  op_w && !stub) || (noise && !op_w && ($urandom % 2 == 1));
    end

    task automatic do_reset();
        reset  = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single-port access driver: returns whether ack came, edges to ack
    // (counting the grant edge), rdata/err at ack, strobe count, and any
    // ack/strobe activity in the 4 cycles after the ack.
    task automatic access(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                          output bit got, output int n, output logic [7:0] rd,
                          output bit er, output int st, output int extra);
        @(negedge clk);
        if (p) begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1; end
        else   begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1; end
        got = 0; n = 0; rd = 0; er = 0; st = 0; extra = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            if (ram_read || ram_write) st++;
            if (p ? m1_ack : m0_ack) begin
                got = 1;
                rd  = p ? m1_rdata : m0_rdata;
                er  = p ? m1_err : m0_err;
            end
        end
        if (p) m1_req = 0; else m0_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack || ram_read || ram_write) extra++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        #3;
        tests++;
        if ({m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err, ram_address,
             ram_data_in, ram_read, ram_write} !== 38'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {m0_rdata, m0_ack, m0_err, m1_rdata,
                     m1_ack, m1_err, ram_address, ram_data_in, ram_read, ram_write});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_p0();
        bit got, er; int n, st, ex; logic [7:0] rd;
        lat = 0;
        mem[8'h12] = 8'hA5;
        access(0, 0, 8'h12, 8'h00, got, n, rd, er, st, ex);
        tests++; if (!got)      begin fails++; $display("FAIL read_p0_ack got=0 exp=1"); end
        tests++; if (n != 3)    begin fails++; $display("FAIL read_p0_latency got=%0d exp=3", n); end
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL read_p0_rdata got=%h exp=a5", rd); end
        tests++; if (er !== 0)  begin fails++; $display("FAIL read_p0_err got=%b exp=0", er); end
        tests++; if (st != 1)   begin fails++; $display("FAIL read_p0_strobe got=%0d exp=1", st); end
        tests++; if (ex != 0)   begin fails++; $display("FAIL read_p0_after got=%0d exp=0", ex); end
    endtask

    task automatic test_write_read_p1();
        bit got, er; int n, st, ex; logic [7:0] rd;
        lat = 0;
        access(1, 1, 8'h40, 8'h3C, got, n, rd, er, st, ex);
        tests++; if (!got || n != 3 || st != 1 || ex != 0) begin
            fails++; $display("FAIL write_p1 got=%b n=%0d st=%0d ex=%0d exp=1/3/1/0", got, n, st, ex);
        end
        tests++; if (mem[8'h40] !== 8'h3C) begin fails++; $display("FAIL write_p1_mem got=%h exp=3c", mem[8'h40]); end
        access(1, 0, 8'h40, 8'h00, got, n, rd, er, st, ex);
        tests++; if (rd !== 8'h3C) begin fails++; $display("FAIL read_p1_rdata got=%h exp=3c", rd); end
        tests++; if (!got || st != 1 || ex != 0 || er !== 0) begin
            fails++; $display("FAIL read_p1_handshake got=%b st=%0d ex=%0d er=%b", got, st, ex, er);
        end
    endtask

    task automatic test_contention();
        int cyc[$]; bit port[$];
        lat = 0;
        mem[8'h50] = 8'h11; mem[8'h51] = 8'h22;
        reset = 1'b1;
        m0_we = 0; m1_we = 0; m0_addr = 8'h50; m1_addr = 8'h51;
        m0_req = 1; m1_req = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (m0_ack) begin cyc.push_back(c); port.push_back(0); end
            if (m1_ack) begin cyc.push_back(c); port.push_back(1); end
        end
        m0_req = 0; m1_req = 0;
        tests++;
        if (cyc.size() != 4) begin
            fails++; $display("FAIL contention_count got=%0d exp=4", cyc.size());
        end else begin
            tests++;
            if (port[0] !== 0 || port[1] !== 1 || port[2] !== 0 || port[3] !== 1) begin
                fails++; $display("FAIL contention_order got=%b%b%b%b exp=0101", port[0], port[1], port[2], port[3]);
            end
            tests++;
            if (cyc[0] != 3 || cyc[1] - cyc[0] != 4 || cyc[2] - cyc[1] != 4 || cyc[3] - cyc[2] != 4) begin
                fails++; $display("FAIL contention_spacing got=%0d,%0d,%0d,%0d exp=3,7,11,15", cyc[0], cyc[1], cyc[2], cyc[3]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [4];
        logic [7:0] seen[$];
        int acks = 0, last_c = 0, bad_gap = 0, bad_rd = 0;
        lat = 1;
        addrs[0] = 8'h60; addrs[1] = 8'h61; addrs[2] = 8'h62; addrs[3] = 8'h63;
        for (int i = 0; i < 4; i++) mem[addrs[i]] = 8'(8'hC0 + i);
        @(negedge clk);
        m0_we = 0; m0_addr = addrs[0]; m0_req = 1;
        for (int c = 1; c <= 60 && acks < 4; c++) begin
            @(posedge clk); #1;
            if (ram_read || ram_write) seen.push_back(ram_address);
            if (m0_ack) begin
                if (m0_rdata !== 8'(8'hC0 + acks)) bad_rd++;
                if (acks > 0 && c - last_c != 5) bad_gap++;
                last_c = c;
                acks++;
                if (acks < 4) m0_addr = addrs[acks];
            end
        end
        m0_req = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ram_read || ram_write) seen.push_back(ram_address);
        end
        tests++; if (acks != 4) begin fails++; $display("FAIL b2b_acks got=%0d exp=4", acks); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL b2b_rdata bad=%0d exp=0", bad_rd); end
        tests++; if (bad_gap != 0) begin fails++; $display("FAIL b2b_gap bad=%0d exp=0", bad_gap); end
        tests++;
        if (seen.size() != 4) begin
            fails++; $display("FAIL b2b_grants got=%0d exp=4", seen.size());
        end else if (seen[0] !== addrs[0] || seen[1] !== addrs[1] || seen[2] !== addrs[2] || seen[3] !== addrs[3]) begin
            fails++; $display("FAIL b2b_addrs got=%h %h %h %h exp=60 61 62 63", seen[0], seen[1], seen[2], seen[3]);
        end
        lat = 0;
    endtask

    task automatic test_timeout();
        bit got, er; int n, st, ex; logic [7:0] rd, prev;
        prev = m0_rdata;
        stub = 1;
        access(0, 0, 8'h12, 8'h00, got, n, rd, er, st, ex);
        stub = 0;
        tests++; if (!got)     begin fails++; $display("FAIL timeout_ack got=0 exp=1"); end
        tests++; if (n != 7)   begin fails++; $display("FAIL timeout_latency got=%0d exp=7", n); end
        tests++; if (er !== 1) begin fails++; $display("FAIL timeout_err got=%b exp=1", er); end
        tests++; if (rd !== prev) begin fails++; $display("FAIL timeout_rdata got=%h exp=%h", rd, prev); end
        tests++; if (ex != 0)  begin fails++; $display("FAIL timeout_after got=%0d exp=0", ex); end
    endtask

    task automatic test_reset_mid();
        int acks = 0, first_p = -1, done0 = 0, done1 = 0;
        logic [7:0] first_a = 8'hxx;
        bit have_a = 0;
        stub = 1;
        @(negedge clk);
        m0_we = 0; m0_addr = 8'h12; m0_req = 1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err, ram_address,
             ram_data_in, ram_read, ram_write} !== 38'd0) begin
            fails++; $display("FAIL reset_mid_outputs got=%h exp=0", {m0_rdata, m0_ack, m0_err,
                     m1_rdata, m1_ack, m1_err, ram_address, ram_data_in, ram_read, ram_write});
        end
        m0_req = 0;
        stub = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL reset_mid_noack got=%0d exp=0", acks); end
        @(negedge clk);
        m0_addr = 8'h21; m1_addr = 8'h22; m0_we = 0; m1_we = 0;
        m0_req = 1; m1_req = 1;
        for (int c = 0; c < 30 && !(done0 && done1); c++) begin
            @(posedge clk); #1;
            if ((ram_read || ram_write) && !have_a) begin first_a = ram_address; have_a = 1; end
            if (m0_ack) begin if (first_p < 0) first_p = 0; done0 = 1; m0_req = 0; end
            if (m1_ack) begin if (first_p < 0) first_p = 1; done1 = 1; m1_req = 0; end
        end
        m0_req = 0; m1_req = 0;
        tests++; if (first_a !== 8'h21) begin fails++; $display("FAIL reset_mid_first_addr got=%h exp=21", first_a); end
        tests++; if (first_p != 0)      begin fails++; $display("FAIL reset_mid_first_ack got=%0d exp=0", first_p); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit last_m = 1;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); shadow[i] = mem[i]; end
        for (int it = 0; it < 30; it++) begin
            int mode, ks, ka, n;
            bit ord[$];
            bit w [2];
            logic [7:0] a [2], d [2], exp_rd [2];
            mode = $urandom_range(0, 2);
            lat = $urandom_range(0, 3);
            noise = ($urandom % 2 == 1);
            for (int p = 0; p < 2; p++) begin
                w[p] = ($urandom % 2 == 1);
                a[p] = 8'(8'h80 + $urandom_range(0, 5));
                d[p] = 8'($urandom);
                exp_rd[p] = 8'h00;
            end
            if (mode == 0) ord = {1'b0};
            else if (mode == 1) ord = {1'b1};
            else if (last_m) ord = {1'b0, 1'b1};
            else ord = {1'b1, 1'b0};
            last_m = ord[ord.size() - 1];
            foreach (ord[k]) begin
                if (w[ord[k]]) shadow[a[ord[k]]] = d[ord[k]];
                else exp_rd[ord[k]] = shadow[a[ord[k]]];
            end
            @(negedge clk);
            m0_we = w[0]; m0_addr = a[0]; m0_wdata = d[0];
            m1_we = w[1]; m1_addr = a[1]; m1_wdata = d[1];
            m0_req = (mode != 1); m1_req = (mode != 0);
            ks = 0; ka = 0; n = 0;
            for (int c = 0; c < 60 && ka < ord.size(); c++) begin
                @(posedge clk); #1;
                n++;
                if (ram_read || ram_write) begin
                    tests++;
                    if (ks >= ord.size()) begin
                        fails++; $display("FAIL rand_extra_strobe it=%0d addr=%h", it, ram_address);
                    end else begin
                        if (ram_address !== a[ord[ks]] || ram_write !== w[ord[ks]]) begin
                            fails++; $display("FAIL rand_grant it=%0d got=%h/%b exp=%h/%b", it,
                                     ram_address, ram_write, a[ord[ks]], w[ord[ks]]);
                        end
                        // Operands may change after the grant edge.
                        if (ord[ks]) begin m1_addr = 8'($urandom); m1_wdata = 8'($urandom); end
                        else         begin m0_addr = 8'($urandom); m0_wdata = 8'($urandom); end
                    end
                    ks++;
                end
                for (int p = 0; p < 2; p++) begin
                    if (p == 1 ? m1_ack : m0_ack) begin
                        tests++;
                        if (ka >= ord.size() || ord[ka] != p[0]) begin
                            fails++; $display("FAIL rand_ack_order it=%0d port=%0d idx=%0d", it, p, ka);
                        end
                        tests++;
                        if ((p == 1 ? m1_err : m0_err) !== 0) begin
                            fails++; $display("FAIL rand_err it=%0d port=%0d got=1 exp=0", it, p);
                        end
                        if (!w[p]) begin
                            tests++;
                            if ((p == 1 ? m1_rdata : m0_rdata) !== exp_rd[p]) begin
                                fails++; $display("FAIL rand_rdata it=%0d port=%0d got=%h exp=%h", it, p,
                                         (p == 1 ? m1_rdata : m0_rdata), exp_rd[p]);
                            end
                        end
                        if (ka == 0) begin
                            tests++;
                            if (n != 3 + lat) begin
                                fails++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, n, 3 + lat);
                            end
                        end
                        ka++;
                        if (p == 1) m1_req = 0; else m0_req = 0;
                    end
                end
            end
            m0_req = 0; m1_req = 0;
            tests++;
            if (ka != ord.size()) begin
                fails++; $display("FAIL rand_ack_count it=%0d got=%0d exp=%0d", it, ka, ord.size());
            end
            repeat (2) @(posedge clk);
        end
        lat = 0; noise = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rand_mem_image bad=%0d exp=0", bad); end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_read_p0();
        test_write_read_p1();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
